// File: rtl/uart_config_responder.sv
// uart_config_responder: slave end of the UART configuration handshake.
// Detects the init low pulse, acks with 8'hFF, stages and commits config.
module uart_config_responder #(
  parameter int INIT_COUNT    = 1_000_000,
  parameter int TIMEOUT_COUNT = 5_000_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_line_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] tx_data_o,
  output logic       tx_req_o,
  input  logic       tx_done_i,
  output logic [5:0] cfg_o,
  output logic       cfg_active_o,
  output logic       cfg_done_o,
  output logic       cfg_fail_o
);

  localparam int LW =
    (INIT_COUNT > 1) ? $clog2(INIT_COUNT) : 1;
  localparam int TW =
    (TIMEOUT_COUNT > 1) ? $clog2(TIMEOUT_COUNT) : 1;

  localparam logic [LW-1:0] LOW_MAX =
    LW'(INIT_COUNT - 1);
  localparam logic [TW-1:0] TO_MAX =
    TW'(TIMEOUT_COUNT - 1);

  localparam logic [1:0] END_CONFIGURATION = 2'b00;
  localparam logic [1:0] DATA_WIDTH_ID     = 2'b01;
  localparam logic [1:0] STOP_BITS_ID      = 2'b10;
  localparam logic [1:0] PARITY_MODE_ID    = 2'b11;
  localparam logic [1:0] SB_RESERVED       = 2'b10;

  localparam logic [5:0] CFG_RESET = 6'b11_11_01;
  localparam logic [7:0] ACKN_PKT  = 8'hFF;

  typedef enum logic [2:0] {
    MAIN,
    WAIT_RELEASE,
    SEND_ACKN,
    WAIT_PKT,
    FAIL
  } state_t;

  state_t        state;
  logic [LW-1:0] low_cnt;
  logic [TW-1:0] to_cnt;
  logic [5:0]    staged;
  logic          commit;

  logic [1:0] id;
  logic [1:0] option;
  logic       unused_hi;

  assign id        = rx_data_i[1:0];
  assign option    = rx_data_i[3:2];
  assign unused_hi = ^rx_data_i[7:4];

  assign cfg_active_o = (state != MAIN);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= MAIN;
      low_cnt    <= '0;
      to_cnt     <= '0;
      staged     <= CFG_RESET;
      commit     <= 1'b0;
      cfg_o      <= CFG_RESET;
      tx_data_o  <= '0;
      tx_req_o   <= 1'b0;
      cfg_done_o <= 1'b0;
      cfg_fail_o <= 1'b0;
    end else begin
      cfg_done_o <= 1'b0;
      cfg_fail_o <= 1'b0;
      unique case (state)
        MAIN: begin
          if (rx_line_i) begin
            low_cnt <= '0;
          end else if (low_cnt == LOW_MAX) begin
            low_cnt <= '0;
            state   <= WAIT_RELEASE;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end

        WAIT_RELEASE: begin
          if (rx_line_i) begin
            state     <= SEND_ACKN;
            tx_req_o  <= 1'b1;
            tx_data_o <= ACKN_PKT;
          end
        end

        SEND_ACKN: begin
          if (tx_done_i) begin
            tx_req_o  <= 1'b0;
            tx_data_o <= '0;
            if (commit) begin
              state  <= MAIN;
              commit <= 1'b0;
            end else begin
              state  <= WAIT_PKT;
              to_cnt <= '0;
            end
          end
        end

        WAIT_PKT: begin
          // a packet arriving on the timeout cycle still wins
          if (rx_valid_i) begin
            state     <= SEND_ACKN;
            tx_req_o  <= 1'b1;
            tx_data_o <= ACKN_PKT;
            unique case (id)
              DATA_WIDTH_ID: begin
                staged[5:4] <= option;
              end
              STOP_BITS_ID: begin
                if (option == SB_RESERVED) begin
                  state      <= FAIL;
                  tx_req_o   <= 1'b0;
                  tx_data_o  <= '0;
                  cfg_fail_o <= 1'b1;
                end else begin
                  staged[3:2] <= option;
                end
              end
              PARITY_MODE_ID: begin
                staged[1:0] <= option;
              end
              END_CONFIGURATION: begin
                cfg_o      <= staged;
                cfg_done_o <= 1'b1;
                commit     <= 1'b1;
              end
              default: ;
            endcase
          end else if (to_cnt == TO_MAX) begin
            state      <= FAIL;
            cfg_fail_o <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        FAIL: begin
          staged <= cfg_o;
          commit <= 1'b0;
          state  <= MAIN;
        end

        default: begin
          state <= MAIN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_config_responder.sv
// tb_uart_config_responder: directed bench for uart_config_responder.
// INIT_COUNT=16, TIMEOUT_COUNT=64; inputs change 1 ns after posedge.
module tb_uart_config_responder;

  logic       clk;
  logic       rst_n;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_done;
  logic [5:0] cfg;
  logic       cfg_active;
  logic       cfg_done;
  logic       cfg_fail;

  int compared;
  int mismatched;

  uart_config_responder #(
    .INIT_COUNT(16),
    .TIMEOUT_COUNT(64)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .rx_line_i(rx_line),
    .rx_data_i(rx_data),
    .rx_valid_i(rx_valid),
    .tx_data_o(tx_data),
    .tx_req_o(tx_req),
    .tx_done_i(tx_done),
    .cfg_o(cfg),
    .cfg_active_o(cfg_active),
    .cfg_done_o(cfg_done),
    .cfg_fail_o(cfg_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // init pulse then release; ends in SEND_ACKN
  task automatic do_init();
    rx_line = 1'b0;
    repeat (16) tick();
    rx_line = 1'b1;
    tick();
  endtask

  task automatic ack();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic test_reset();
    compared++;
    if (cfg !== 6'b11_11_01) begin
      $display("FAIL reset_cfg: got %b want 111101", cfg);
      mismatched++;
    end
    compared++;
    if ({tx_req, cfg_active, cfg_done, cfg_fail} !== 4'b0000) begin
      $display("FAIL reset_flags: got %b want 0000",
               {tx_req, cfg_active, cfg_done, cfg_fail});
      mismatched++;
    end
    compared++;
    if (tx_data !== 8'h00) begin
      $display("FAIL reset_txdata: got %h want 00", tx_data);
      mismatched++;
    end
  endtask

  task automatic test_init_ack();
    rx_line = 1'b0;
    repeat (16) tick();
    compared++;
    if ({cfg_active, tx_req} !== 2'b10) begin
      $display("FAIL init_wait_release: got %b want 10",
               {cfg_active, tx_req});
      mismatched++;
    end
    rx_line = 1'b1;
    tick();
    compared++;
    if ({tx_req, tx_data} !== {1'b1, 8'hFF}) begin
      $display("FAIL init_ack: got req=%b data=%h want 1 ff",
               tx_req, tx_data);
      mismatched++;
    end
    ack();
    compared++;
    if ({cfg_active, tx_req} !== 2'b10) begin
      $display("FAIL init_wait_pkt: got %b want 10",
               {cfg_active, tx_req});
      mismatched++;
    end
    send_pkt(8'h00);
    compared++;
    if ({cfg_done, tx_req, cfg} !== {2'b11, 6'b11_11_01}) begin
      $display("FAIL init_end: got done=%b req=%b cfg=%b want 1 1 111101",
               cfg_done, tx_req, cfg);
      mismatched++;
    end
    ack();
    compared++;
    if ({cfg_active, cfg_done} !== 2'b00) begin
      $display("FAIL init_to_main: got %b want 00",
               {cfg_active, cfg_done});
      mismatched++;
    end
  endtask

  task automatic test_illegal();
    do_init();
    ack();
    send_pkt(8'h0A);
    compared++;
    if ({cfg_fail, tx_req, cfg_active} !== 3'b101) begin
      $display("FAIL illegal_pulse: got %b want 101",
               {cfg_fail, tx_req, cfg_active});
      mismatched++;
    end
    tick();
    compared++;
    if ({cfg_fail, cfg_active, tx_req, cfg} !== {3'b000, 6'b11_11_01}) begin
      $display("FAIL illegal_after: got f=%b a=%b r=%b cfg=%b want 0 0 0 111101",
               cfg_fail, cfg_active, tx_req, cfg);
      mismatched++;
    end
  endtask

  task automatic test_timeout();
    do_init();
    ack();
    repeat (63) tick();
    compared++;
    if ({cfg_fail, cfg_active} !== 2'b01) begin
      $display("FAIL timeout_early: got %b want 01",
               {cfg_fail, cfg_active});
      mismatched++;
    end
    tick();
    compared++;
    if (cfg_fail !== 1'b1) begin
      $display("FAIL timeout_pulse: got %b want 1", cfg_fail);
      mismatched++;
    end
    tick();
    compared++;
    if ({cfg_fail, cfg_active, cfg} !== {2'b00, 6'b11_11_01}) begin
      $display("FAIL timeout_after: got f=%b a=%b cfg=%b want 0 0 111101",
               cfg_fail, cfg_active, cfg);
      mismatched++;
    end
  endtask

  task automatic test_fail_reload();
    do_init();
    ack();
    send_pkt(8'h09);
    ack();
    send_pkt(8'h0A);
    tick();
    do_init();
    ack();
    send_pkt(8'h00);
    compared++;
    if ({cfg_done, cfg} !== {1'b1, 6'b11_11_01}) begin
      $display("FAIL fail_reload: got done=%b cfg=%b want 1 111101",
               cfg_done, cfg);
      mismatched++;
    end
    ack();
  endtask

  task automatic test_short_pulse();
    int bad;
    bad = 0;
    rx_line = 1'b0;
    repeat (15) begin
      tick();
      if (cfg_active !== 1'b0 || tx_req !== 1'b0) bad++;
    end
    rx_line = 1'b1;
    tick();
    if (cfg_active !== 1'b0 || tx_req !== 1'b0) bad++;
    rx_line = 1'b0;
    repeat (15) begin
      tick();
      if (cfg_active !== 1'b0 || tx_req !== 1'b0) bad++;
    end
    rx_line = 1'b1;
    repeat (3) begin
      tick();
      if (cfg_active !== 1'b0 || tx_req !== 1'b0) bad++;
    end
    compared++;
    if (bad !== 0) begin
      $display("FAIL short_pulse: got %0d active cycles want 0", bad);
      mismatched++;
    end
  endtask

  task automatic test_config();
    logic [7:0] pkts [4];
    int acks;
    int dones;
    pkts = '{8'h05, 8'h0E, 8'h07, 8'h00};
    acks  = 0;
    dones = 0;
    do_init();
    ack();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        compared++;
        if (cfg !== 6'b11_11_01) begin
          $display("FAIL cfg_before_end: got %b want 111101", cfg);
          mismatched++;
        end
      end
      send_pkt(pkts[i]);
      if (tx_req === 1'b1 && tx_data === 8'hFF) acks++;
      if (cfg_done === 1'b1) dones++;
      ack();
      if (cfg_done === 1'b1) dones++;
    end
    compared++;
    if (acks !== 4) begin
      $display("FAIL cfg_acks: got %0d want 4", acks);
      mismatched++;
    end
    compared++;
    if (dones !== 1) begin
      $display("FAIL cfg_done_count: got %0d want 1", dones);
      mismatched++;
    end
    compared++;
    if ({cfg_active, cfg} !== {1'b0, 6'b01_11_01}) begin
      $display("FAIL cfg_commit: got a=%b cfg=%b want 0 011101",
               cfg_active, cfg);
      mismatched++;
    end
  endtask

  task automatic test_tie();
    do_init();
    ack();
    repeat (63) tick();
    send_pkt(8'h01);
    compared++;
    if ({cfg_fail, tx_req, tx_data} !== {2'b01, 8'hFF}) begin
      $display("FAIL tie_packet_wins: got f=%b r=%b d=%h want 0 1 ff",
               cfg_fail, tx_req, tx_data);
      mismatched++;
    end
    ack();
    send_pkt(8'h00);
    ack();
    compared++;
    if ({cfg_active, cfg} !== {1'b0, 6'b00_11_01}) begin
      $display("FAIL tie_commit: got a=%b cfg=%b want 0 001101",
               cfg_active, cfg);
      mismatched++;
    end
  endtask

  task automatic test_back_to_back();
    send_pkt(8'h00);
    compared++;
    if ({cfg_done, cfg_active, tx_req} !== 3'b000) begin
      $display("FAIL ignore_main: got %b want 000",
               {cfg_done, cfg_active, tx_req});
      mismatched++;
    end
    do_init();
    ack();
    send_pkt(8'hF9);
    send_pkt(8'h00);
    compared++;
    if ({cfg_done, tx_req, cfg} !== {2'b01, 6'b00_11_01}) begin
      $display("FAIL ignore_send_ackn: got d=%b r=%b cfg=%b want 0 1 001101",
               cfg_done, tx_req, cfg);
      mismatched++;
    end
    ack();
    send_pkt(8'h3D);
    ack();
    send_pkt(8'h8B);
    ack();
    send_pkt(8'h42);
    ack();
    send_pkt(8'h00);
    compared++;
    if ({cfg_done, cfg} !== {1'b1, 6'b11_00_10}) begin
      $display("FAIL overwrite_commit: got d=%b cfg=%b want 1 110010",
               cfg_done, cfg);
      mismatched++;
    end
    ack();
  endtask

  task automatic test_reset_mid();
    do_init();
    ack();
    send_pkt(8'h05);
    rst_n = 1'b0;
    #2;
    compared++;
    if ({tx_req, cfg_active, cfg_done, cfg_fail, tx_data, cfg} !==
        {4'b0000, 8'h00, 6'b11_11_01}) begin
      $display("FAIL reset_mid: got r=%b a=%b d=%b f=%b td=%h cfg=%b",
               tx_req, cfg_active, cfg_done, cfg_fail, tx_data, cfg);
      mismatched++;
    end
    #1;
    rst_n = 1'b1;
    tick();
    do_init();
    ack();
    send_pkt(8'h00);
    compared++;
    if ({cfg_done, cfg} !== {1'b1, 6'b11_11_01}) begin
      $display("FAIL reset_staged: got d=%b cfg=%b want 1 111101",
               cfg_done, cfg);
      mismatched++;
    end
    ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n    = 1'b0;
    rx_line  = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_init_ack();
    test_illegal();
    test_timeout();
    test_fail_reload();
    test_short_pulse();
    test_config();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
